bcd_sub_serial: RTL and testbench

Digit-serial packed-BCD subtractor. It computes minuend − subtrahend one decimal digit per clock, least-significant digit first, and propagates a borrow between digits. It is the decrement counterpart of the combinational BCD adder. Game logic uses it to decrement BCD counters (lives, fuel, shield, timer). A start/busy/done handshake lets one instance be shared by several counters.

---
 rtl/bcd_sub_serial.sv | 143 ++++++++++++++
 tb/tb_bcd_sub_serial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: one decimal digit per clock, least-significant first.
// Start/busy/done handshake lets one instance serve several BCD counters.
module bcd_sub_serial #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIGITS-1:0][3:0] minuend,
  input  logic [DIGITS-1:0][3:0] subtrahend,
  output logic                   busy,
  output logic                   done,
  output logic [DIGITS-1:0][3:0] result,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  a_q, a_d;
  logic [DIGITS-1:0][3:0]  b_q, b_d;
  logic [DIGITS-1:0][3:0]  sh_q, sh_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    borrow_q, borrow_d;
  logic                    inv_acc_q, inv_acc_d;
  logic [DIGITS-1:0][3:0]  result_q, result_d;
  logic                    underflow_q, underflow_d;
  logic                    invalid_q, invalid_d;

  logic [3:0]        a_digit;
  logic [3:0]        b_digit;
  logic signed [5:0] diff;
  logic signed [5:0] diff_adj;
  logic              diff_neg;
  logic [3:0]        digit_out;
  logic              any_invalid;

  // Current digit difference; a negative value borrows ten from the next digit.
  always_comb begin
    a_digit   = a_q[idx_q];
    b_digit   = b_q[idx_q];
    diff      = $signed({2'b00, a_digit}) - $signed({2'b00, b_digit})
                - $signed({5'b00000, borrow_q});
    diff_adj  = diff + 6'sd10;
    diff_neg  = diff[5];
    digit_out = diff_neg ? diff_adj[3:0] : diff[3:0];
  end

  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (minuend[i] > 4'd9 || subtrahend[i] > 4'd9) begin
        any_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    inv_acc_d   = inv_acc_q;
    result_d    = result_q;
    underflow_d = underflow_q;
    invalid_d   = invalid_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts start so back-to-back operations lose no cycle.
        if (start) begin
          a_d       = minuend;
          b_d       = subtrahend;
          sh_d      = '0;
          idx_d     = '0;
          borrow_d  = 1'b0;
          inv_acc_d = any_invalid;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sh_d[idx_q] = digit_out;
        borrow_d    = diff_neg;
        idx_d       = idx_q + IDXW'(1);
        // Outputs load on the last digit so they are already valid in the done cycle.
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = ST_DONE;
          underflow_d = diff_neg;
          invalid_d   = inv_acc_q;
          result_d    = (SATURATE && diff_neg) ? '0 : sh_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      inv_acc_q   <= 1'b0;
      result_q    <= '0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      inv_acc_q   <= inv_acc_d;
      result_q    <= result_d;
      underflow_q <= underflow_d;
      invalid_q   <= invalid_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign underflow = underflow_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed bench for bcd_sub_serial; a saturating and a wrapping instance share inputs.
module tb_bcd_sub_serial;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [3:0][3:0] minuend;
  logic [3:0][3:0] subtrahend;

  logic            busy_s, done_s, uf_s, inv_s;
  logic [3:0][3:0] result_s;
  logic            busy_w, done_w, uf_w, inv_w;
  logic [3:0][3:0] result_w;

  int checks   = 0;
  int failures = 0;

  bcd_sub_serial #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .minuend(minuend), .subtrahend(subtrahend),
    .busy(busy_s), .done(done_s), .result(result_s), .underflow(uf_s), .invalid(inv_s)
  );

  bcd_sub_serial #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .minuend(minuend), .subtrahend(subtrahend),
    .busy(busy_w), .done(done_w), .result(result_w), .underflow(uf_w), .invalid(inv_w)
  );

  always #5 clk = ~clk;

  // Call just after an accepting edge; counts cycles (sampled at negedge) until done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_s === 1'b1 && done_s !== 1'b1) busy_cnt++;
    end while (done_s !== 1'b1 && lat < 20);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_sat, input logic [15:0] exp_wrap,
                        input logic exp_uf, input logic exp_inv);
    int lat, bcnt;
    @(negedge clk);
    minuend = a; subtrahend = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    minuend = 16'h5555; subtrahend = 16'h4444;
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 5 || done_w !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: got %0d done_w=%b, need 5 done_w=1", name, lat, done_w);
    end
    checks++;
    if (bcnt !== 4 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: got %0d busy cycles busy_at_done=%b, need 4 and 0", name, bcnt, busy_s);
    end
    checks++;
    if (result_s !== exp_sat || result_w !== exp_wrap) begin
      failures++;
      $display("FAIL %s result: got sat=%h wrap=%h, need sat=%h wrap=%h",
               name, result_s, result_w, exp_sat, exp_wrap);
    end
    checks++;
    if (uf_s !== exp_uf || uf_w !== exp_uf || inv_s !== exp_inv || inv_w !== exp_inv) begin
      failures++;
      $display("FAIL %s flags: got uf=%b/%b inv=%b/%b, need uf=%b inv=%b",
               name, uf_s, uf_w, inv_s, inv_w, exp_uf, exp_inv);
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0 || result_s !== exp_sat || result_w !== exp_wrap || uf_s !== exp_uf) begin
      failures++;
      $display("FAIL %s hold: got done=%b sat=%h wrap=%h uf=%b, need done=0 sat=%h wrap=%h uf=%b",
               name, done_s, result_s, result_w, uf_s, exp_sat, exp_wrap, exp_uf);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_s, done_s, uf_s, inv_s, busy_w, done_w} !== 6'b0 || result_s !== 16'h0 || result_w !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h/%h uf=%b inv=%b, need all 0",
               busy_s, done_s, result_s, result_w, uf_s, inv_s);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith;
    run_op("basic",      16'h0042, 16'h0017, 16'h0025, 16'h0025, 1'b0, 1'b0);
    run_op("ripple",     16'h1000, 16'h0001, 16'h0999, 16'h0999, 1'b0, 1'b0);
    run_op("underflow",  16'h0003, 16'h0005, 16'h0000, 16'h9998, 1'b1, 1'b0);
    run_op("min_max",    16'h0000, 16'h9999, 16'h0000, 16'h0001, 1'b1, 1'b0);
    run_op("equal",      16'h9999, 16'h9999, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("b_zero",     16'h1234, 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b0);
    run_op("invalid_a",  16'h00A5, 16'h0001, 16'h00A4, 16'h00A4, 1'b0, 1'b1);
    run_op("invalid_b",  16'h0000, 16'h000F, 16'h0000, 16'h999B, 1'b1, 1'b1);
    run_op("clear_inv",  16'h0500, 16'h0123, 16'h0377, 16'h0377, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, extra;
    @(negedge clk);
    minuend = 16'h0042; subtrahend = 16'h0017; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    minuend = 16'h0500; subtrahend = 16'h0123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done_s !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done_s !== 1'b1 || result_s !== 16'h0025) begin
      failures++;
      $display("FAIL ignore_start result: got done=%b res=%h, need done=1 res=0025", done_s, result_s);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_s === 1'b1 || busy_s === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignore_start queued: got %0d active cycles, need 0", extra);
    end
    bcnt = 0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] op_a [4];
    logic [15:0] op_b [4];
    logic [15:0] exp_r [3];
    int lat, bcnt;
    op_a = '{16'h0042, 16'h0500, 16'h1000, 16'h0001};
    op_b = '{16'h0017, 16'h0123, 16'h0001, 16'h0001};
    exp_r = '{16'h0025, 16'h0377, 16'h0999};
    @(negedge clk);
    minuend = op_a[0]; subtrahend = op_b[0]; start = 1'b1;
    @(posedge clk); #1;
    minuend = op_a[1]; subtrahend = op_b[1];
    for (int k = 0; k < 3; k++) begin
      wait_done(lat, bcnt);
      checks++;
      if (lat !== 5 || result_s !== exp_r[k]) begin
        failures++;
        $display("FAIL back_to_back_%0d: got latency=%0d res=%h, need latency=5 res=%h",
                 k, lat, result_s, exp_r[k]);
      end
      @(posedge clk); #1;
      if (k < 2) begin
        minuend = op_a[k+2]; subtrahend = op_b[k+2];
      end
    end
    start = 1'b0;
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 5 || result_s !== 16'h0000 || uf_s !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_tail: got latency=%0d res=%h uf=%b, need 5 0000 0", lat, result_s, uf_s);
    end
  endtask

  task automatic test_reset_mid_op;
    int extra;
    @(negedge clk);
    minuend = 16'h1234; subtrahend = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || result_s !== 16'h0 || result_w !== 16'h0 || uf_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op: got busy=%b done=%b res=%h/%h uf=%b, need 0 0 0000 0",
               busy_s, done_s, result_s, result_w, uf_w);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_s === 1'b1 || done_w === 1'b1 || busy_s === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL reset_mid_op_no_done: got %0d active cycles, need 0", extra);
    end
    run_op("after_reset", 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_ignore_start;
    run_op("prime", 16'h0042, 16'h0017, 16'h0025, 16'h0025, 1'b0, 1'b0);
    test_reset_mid_op;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
